dis_bcd_conv: RTL and testbench
===============================

Name: dis_bcd_conv

Overview:
- Sequential binary-to-BCD converter that sits between the ultrasonic distance measurement stage and the 7-segment display driver.
- Takes each new 14-bit distance sample on a valid strobe and converts it with shift-and-add-3 (double dabble), one bit per clock.
- Holds 4 packed BCD digits plus an overflow flag, stable, for the display stage.
- Samples arriving mid-conversion are buffered one-deep; the newest sample wins.

Parameters:
DIN_W, 14, width of binary distance input (bits shifted per conversion)
DIGITS, 4, number of BCD output digits
MAX_VAL, 9999, largest displayable value; larger inputs saturate to it

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
din_valid  input  1  one-cycle strobe: din holds a new sample
din  input  DIN_W  binary distance sample, unsigned
bcd_out  output  4*DIGITS  packed BCD result; digit 0 is bits [3:0]
bcd_valid  output  1  one-cycle pulse when bcd_out/ovf update
busy  output  1  high while a conversion is in progress (state != IDLE)
ovf  output  1  last published result was saturated (input > MAX_VAL)
blank_n  output  DIGITS  per-digit enable for display, active-high (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE, bcd_out=0, bcd_valid=0, busy=0, ovf=0, pending flag=0, blank_n=1 in bit 0 and 0 elsewhere (all ones without the feature).
- A conversion in progress is abandoned with no bcd_valid; nothing restarts until a new din_valid after rst deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On a clock edge with din_valid=1: capture sat(din) into the shift register and clear the BCD scratch.
  - Record ovf_next = (din > MAX_VAL); sat(din) = MAX_VAL if din > MAX_VAL, else din.
  - Bit counter = DIN_W; go to SHIFT.
- SHIFT: each edge, add 3 to every scratch digit >= 5, then shift {scratch, binary} left 1. Decrement the counter; after DIN_W shifts go to DONE.
- DONE, single edge:
  - bcd_out <= scratch, ovf <= ovf_next, bcd_valid <= 1 (deasserted next edge).
  - If pending=1, load the pending sample as in IDLE, clear pending and go to SHIFT; otherwise go to IDLE.
- Latency: capture edge E0 → bcd_valid high in the cycle following edge E(DIN_W+1), i.e. E15 at default width. Throughput: one result per DIN_W+1 cycles.
- din_valid while busy: the sample is written to the pending register (later one overwrites earlier) and pending=1.
- din_valid on the DONE edge itself: that sample is the one loaded next, whether or not pending was set; pending cleared.
- bcd_out and ovf change only on the DONE edge; they are stable otherwise.
- Scratch width: 4*DIGITS bits; with saturation, no digit exceeds 9 and no carry is lost.

Optional Feature:
- Macro DIS_BCD_BLANK_EN.
- Defined: blank_n is registered on the DONE edge together with bcd_out. blank_n[i]=0 when digit i and all higher digits are zero, for i>=1; blank_n[0] is always 1. Result 0042 → blank_n=4'b0011.
- Undefined: blank_n is constant all ones (4'b1111), no blanking logic is synthesised, and the port remains present.

Test Plan:
1. din=1234 pulsed once → busy high 15 cycles; bcd_out=16'h1234 with one-cycle bcd_valid at E15; ovf=0.
2. din=9999, then din=10000, then din=16383 (each after completion) → 16'h9999 ovf=0; 16'h9999 ovf=1; 16'h9999 ovf=1.
3. din=0 → bcd_out=16'h0000; blank_n=4'b0001 with DIS_BCD_BLANK_EN, 4'b1111 without. din=42 → blank_n=4'b0011 / 4'b1111.
4. din=5 at E0, din=77 at E3, din=300 at E8 → exactly two bcd_valid pulses: 16'h0005 at E15, 16'h0300 at E30; 77 never appears.
5. din=8 at E0, din=61 coincident with the DONE edge E15 → 16'h0008 at E15, then 16'h0061 at E30; busy never drops between.
6. din=4321, rst asserted at E7 for 2 cycles → all outputs zero immediately; no bcd_valid after release until a new din_valid.

Source files
------------

// File: rtl/dis_bcd_conv.sv
// -----------------------------------------------------------------------------
// dis_bcd_conv
//
// Sequential binary-to-BCD converter placed between the ultrasonic distance
// measurement stage and the 7-segment display driver. Each accepted sample is
// saturated to MAX_VAL and converted with shift-and-add-3 (double dabble), one
// input bit per clock. The result is held stable for the display until the
// next conversion completes.
//
// Samples arriving while a conversion is running go into a one-deep pending
// register; a later sample overwrites an earlier one. A sample presented on
// the completion (DONE) edge is taken directly as the next conversion.
//
// Optional feature (compile-time macro DIS_BCD_BLANK_EN):
//   defined   : blank_n is registered with bcd_out and blanks leading zero
//               digits (digit 0 is never blanked).
//   undefined : blank_n is tied to all ones; the port is still present.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   din_valid  in   one-cycle strobe: din holds a new sample
//   din        in   [DIN_W]     unsigned binary distance sample
//   bcd_out    out  [4*DIGITS]  packed BCD result, digit 0 in bits [3:0]
//   bcd_valid  out  one-cycle pulse when bcd_out/ovf/blank_n update
//   busy       out  high while a conversion is in progress (state != IDLE)
//   ovf        out  last published result was saturated (input > MAX_VAL)
//   blank_n    out  [DIGITS]    per-digit display enable, active-high
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dis_bcd_conv #(
    parameter int DIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    input  logic [DIN_W-1:0]      din,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank_n
);

    localparam int               BCD_W = 4 * DIGITS;
    localparam int               CNT_W = $clog2(DIN_W + 1);
    localparam logic [DIN_W-1:0] MAX_D = DIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [DIN_W-1:0]   bin_q,       bin_d;       // binary bits still to shift out
    logic [BCD_W-1:0]   scratch_q,   scratch_d;   // BCD digits under construction
    logic [CNT_W-1:0]   cnt_q,       cnt_d;       // shifts remaining
    logic               ovf_next_q,  ovf_next_d;  // saturation flag of the sample in flight
    logic               pending_q,   pending_d;
    logic [DIN_W-1:0]   pend_din_q,  pend_din_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               ovf_q,       ovf_d;

    // Loader shared by IDLE (fresh sample) and DONE (back-to-back sample).
    logic               load_en;
    logic [DIN_W-1:0]   load_raw;
    logic [DIN_W-1:0]   load_sat;
    logic [BCD_W-1:0]   scratch_adj;

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        ovf_next_d  = ovf_next_q;
        pending_d   = pending_q;
        pend_din_d  = pend_din_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        ovf_d       = ovf_q;
        load_en     = 1'b0;
        load_raw    = din;
        scratch_adj = scratch_q;

        // Add-3 correction: any digit >= 5 would become >= 10 after doubling,
        // so pre-bias it so the doubled value carries into the next digit.
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    load_en  = 1'b1;
                    load_raw = din;
                end
            end

            SHIFT: begin
                scratch_d = {scratch_adj[BCD_W-2:0], bin_q[DIN_W-1]};
                bin_d     = {bin_q[DIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
                if (din_valid) begin
                    pend_din_d = din;
                    pending_d  = 1'b1;
                end
            end

            DONE: begin
                bcd_d       = scratch_q;
                ovf_d       = ovf_next_q;
                bcd_valid_d = 1'b1;
                pending_d   = 1'b0;
                state_d     = IDLE;
                // A sample on this very edge is newer than anything pending.
                if (din_valid) begin
                    load_en  = 1'b1;
                    load_raw = din;
                end else if (pending_q) begin
                    load_en  = 1'b1;
                    load_raw = pend_din_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturation keeps every digit <= 9, so the scratch never overflows.
        load_sat = (load_raw > MAX_D) ? MAX_D : load_raw;

        if (load_en) begin
            bin_d      = load_sat;
            scratch_d  = '0;
            ovf_next_d = (load_raw > MAX_D);
            cnt_d      = CNT_LOAD;
            state_d    = SHIFT;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            ovf_next_q  <= 1'b0;
            pending_q   <= 1'b0;
            pend_din_q  <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            ovf_next_q  <= ovf_next_d;
            pending_q   <= pending_d;
            pend_din_q  <= pend_din_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // Leading-zero blanking
    // -------------------------------------------------------------------------
`ifdef DIS_BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = DIGITS'(1);

    logic [DIGITS-1:0] blank_calc;
    logic [DIGITS-1:0] blank_q, blank_d;

    // Digit i is lit when it or any more significant digit is non-zero.
    always_comb begin
        blank_calc    = '0;
        blank_calc[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            blank_calc[i] = |(scratch_q >> (4 * i));
        end
        blank_d = (state_q == DONE) ? blank_calc : blank_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= BLANK_RST;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_n = blank_q;
`else
    assign blank_n = '1;
`endif

endmodule

// File: tb/tb_dis_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_dis_bcd_conv
//
// Self-checking bench for dis_bcd_conv. Expected results come from an
// arithmetic reference model (decimal digit extraction with / and %), a
// table of directed vectors, and scheduled multi-sample sequences covering
// the pending register, the DONE-edge hand-off and asynchronous reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dis_bcd_conv;

    localparam int DIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int MAX_VAL = 9999;
    localparam int LAT     = DIN_W + 1;
`ifdef DIS_BCD_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef int ev_arr_t [4];

    typedef struct {
        int          din;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank_on;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                din_valid;
    logic [DIN_W-1:0]    din;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                busy;
    logic                ovf;
    logic [DIGITS-1:0]   blank_n;

    int checks = 0;
    int errors = 0;

    // Observations from the last scheduled run.
    int          obs_e [$];
    logic [15:0] obs_v [$];
    logic        obs_o [$];
    logic [3:0]  obs_b [$];
    int          busy_drop;
    logic [15:0] pre_bcd;

    always #5 clk = ~clk;

    dis_bcd_conv #(
        .DIN_W   (DIN_W),
        .DIGITS  (DIGITS),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .ovf       (ovf),
        .blank_n   (blank_n)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat(input int v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int s;
        r = '0;
        s = sat(v);
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_blank(input int v);
        logic [3:0] r;
        int p;
        if (!BLANK_EN) return 4'b1111;
        r = 4'b0001;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (sat(v) / p) != 0;
            p = p * 10;
        end
        return r;
    endfunction

    // Runs n edges starting from a falling edge. Before edge e, din_valid is
    // raised if some event is scheduled for e. Records every bcd_valid pulse.
    task automatic run_sched(input int n, input ev_arr_t ev_e, input ev_arr_t ev_d, input int n_ev);
        obs_e.delete(); obs_v.delete(); obs_o.delete(); obs_b.delete();
        busy_drop = -1;
        pre_bcd   = bcd_out;
        for (int e = 0; e < n; e++) begin
            din_valid = 1'b0;
            for (int j = 0; j < n_ev; j++) begin
                if (ev_e[j] == e) begin
                    din_valid = 1'b1;
                    din       = DIN_W'(ev_d[j]);
                end
            end
            @(negedge clk);
            if (e == LAT - 1) pre_bcd = bcd_out;
            if (bcd_valid) begin
                obs_e.push_back(e);
                obs_v.push_back(bcd_out);
                obs_o.push_back(ovf);
                obs_b.push_back(blank_n);
            end
            if (!busy && busy_drop < 0) busy_drop = e;
        end
        din_valid = 1'b0;
    endtask

    // Single conversion followed by the standard result checks.
    task automatic convert_check(input string tag, input int v, input logic [15:0] eb,
                                 input logic eo, input logic [3:0] ebl);
        run_sched(LAT + 2, '{0, -1, -1, -1}, '{v, 0, 0, 0}, 1);
        check({tag, " pulses"}, obs_e.size(), 1);
        if (obs_e.size() == 1) begin
            check({tag, " latency"}, obs_e[0], LAT);
            check({tag, " bcd"}, obs_v[0], eb);
            check({tag, " ovf"}, obs_o[0], eo);
            check({tag, " blank"}, obs_b[0], ebl);
        end
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1234,  16'h1234, 1'b0, 4'b1111};
        vecs[1]  = '{9999,  16'h9999, 1'b0, 4'b1111};
        vecs[2]  = '{10000, 16'h9999, 1'b1, 4'b1111};
        vecs[3]  = '{16383, 16'h9999, 1'b1, 4'b1111};
        vecs[4]  = '{0,     16'h0000, 1'b0, 4'b0001};
        vecs[5]  = '{42,    16'h0042, 1'b0, 4'b0011};
        vecs[6]  = '{5,     16'h0005, 1'b0, 4'b0001};
        vecs[7]  = '{100,   16'h0100, 1'b0, 4'b0111};
        vecs[8]  = '{9,     16'h0009, 1'b0, 4'b0001};
        vecs[9]  = '{1000,  16'h1000, 1'b0, 4'b1111};
        vecs[10] = '{8191,  16'h8191, 1'b0, 4'b1111};

        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        #1;
        check("reset bcd_out", bcd_out, 16'h0000);
        check("reset bcd_valid", bcd_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset ovf", ovf, 1'b0);
        check("reset blank_n", blank_n, BLANK_EN ? 4'b0001 : 4'b1111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: busy profile, latency and output stability for 1234.
        run_sched(LAT + 2, '{0, -1, -1, -1}, '{1234, 0, 0, 0}, 1);
        check("t1 pulses", obs_e.size(), 1);
        if (obs_e.size() == 1) begin
            check("t1 latency", obs_e[0], LAT);
            check("t1 bcd", obs_v[0], 16'h1234);
            check("t1 ovf", obs_o[0], 1'b0);
        end
        check("t1 busy cycles", busy_drop, LAT);
        check("t1 bcd stable before done", pre_bcd, 16'h0000);

        // Directed table (saturation bounds, zeros, blanking).
        foreach (vecs[i]) begin
            convert_check($sformatf("vec%0d", i), vecs[i].din, vecs[i].bcd, vecs[i].ovf,
                          BLANK_EN ? vecs[i].blank_on : 4'b1111);
        end

        // Test 4: pending overwrite, 77 must never appear.
        run_sched(2 * LAT + 3, '{0, 3, 8, -1}, '{5, 77, 300, 0}, 3);
        check("t4 pulses", obs_e.size(), 2);
        if (obs_e.size() == 2) begin
            check("t4 first edge", obs_e[0], LAT);
            check("t4 first bcd", obs_v[0], 16'h0005);
            check("t4 second edge", obs_e[1], 2 * LAT);
            check("t4 second bcd", obs_v[1], 16'h0300);
        end

        // Test 5: sample on the DONE edge is chained directly.
        run_sched(2 * LAT + 3, '{0, LAT, -1, -1}, '{8, 61, 0, 0}, 2);
        check("t5 pulses", obs_e.size(), 2);
        if (obs_e.size() == 2) begin
            check("t5 first edge", obs_e[0], LAT);
            check("t5 first bcd", obs_v[0], 16'h0008);
            check("t5 second edge", obs_e[1], 2 * LAT);
            check("t5 second bcd", obs_v[1], 16'h0061);
        end
        check("t5 busy held", busy_drop, 2 * LAT);

        // Test 6: asynchronous reset mid-conversion.
        check("t6 bcd before reset", bcd_out, 16'h0061);
        din_valid = 1'b1;
        din       = DIN_W'(4321);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("t6 reset bcd_out", bcd_out, 16'h0000);
        check("t6 reset busy", busy, 1'b0);
        check("t6 reset bcd_valid", bcd_valid, 1'b0);
        check("t6 reset ovf", ovf, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sched(2 * LAT, '{-1, -1, -1, -1}, '{0, 0, 0, 0}, 0);
        check("t6 no pulse after release", obs_e.size(), 0);
        check("t6 idle after release", busy_drop, 0);
        convert_check("t6 restart", 4321, 16'h4321, 1'b0, ref_blank(4321));

        // Random single conversions against the arithmetic model.
        for (int k = 0; k < 30; k++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 16383))
                                            : int'($urandom_range(0, 9999));
            convert_check($sformatf("rand%0d(%0d)", k, v), v, ref_bcd(v), v > MAX_VAL, ref_blank(v));
        end

        // Random pending traffic: the newest sample seen on edges 1..LAT wins.
        for (int k = 0; k < 10; k++) begin
            ev_arr_t ee, dd;
            int n_ev, win;
            n_ev = 1 + int'($urandom_range(1, 3));
            ee[0] = 0;
            dd[0] = int'($urandom_range(0, 16383));
            for (int j = 1; j < 4; j++) begin
                ee[j] = (j == 1) ? int'($urandom_range(1, 5))
                                 : ee[j-1] + int'($urandom_range(1, 5));
                if (ee[j] > LAT) ee[j] = LAT;
                dd[j] = int'($urandom_range(0, 16383));
            end
            // Later entries with the same edge overwrite; last writer wins.
            win = dd[n_ev - 1];
            run_sched(2 * LAT + 3, ee, dd, n_ev);
            check($sformatf("prand%0d pulses", k), obs_e.size(), 2);
            if (obs_e.size() == 2) begin
                check($sformatf("prand%0d first", k), obs_v[0], ref_bcd(dd[0]));
                check($sformatf("prand%0d first ovf", k), obs_o[0], dd[0] > MAX_VAL);
                check($sformatf("prand%0d second", k), obs_v[1], ref_bcd(win));
                check($sformatf("prand%0d second ovf", k), obs_o[1], win > MAX_VAL);
                check($sformatf("prand%0d second edge", k), obs_e[1], 2 * LAT);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
